// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and data access.
// Data has priority; a saturating starvation counter forces a fetch grant after STARVE_MAX losses.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        inst_rready,
  input  logic        data_req,
  input  logic [3:0]  data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  input  logic        data_rready,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]  state;
  logic        owner;      // 0: fetch, 1: data
  logic        is_write;
  logic [31:0] hold_q;
  logic [3:0]  starve_cnt;
  logic        rst_q;

  logic        blk;
  logic        owner_rready;
  logic        can_issue;
  logic        starve_hit;
  logic        resp_valid;
  logic [31:0] resp_data;

  // rst_q keeps every output quiet for the cycle following reset as well.
  always_comb begin
    blk          = rst | rst_q;
    owner_rready = owner ? data_rready : inst_rready;
    can_issue    = !blk && ((state == S_IDLE) || owner_rready);
    starve_hit   = inst_req && (starve_cnt == STARVE_LIM);

    inst_gnt = can_issue && inst_req && (starve_hit || !data_req);
    data_gnt = can_issue && data_req && !starve_hit;

    resp_valid = !rst && (state != S_IDLE);
    resp_data  = (state == S_WAIT) ? (is_write ? '0 : sram_rdata) : hold_q;

    inst_rvalid = resp_valid && !owner;
    data_rvalid = resp_valid && owner;
    inst_rdata  = inst_rvalid ? resp_data : '0;
    data_rdata  = data_rvalid ? resp_data : '0;

    sram_en    = inst_gnt | data_gnt;
    sram_we    = data_gnt ? data_we : '0;
    sram_addr  = data_gnt ? data_addr : (inst_gnt ? inst_addr : '0);
    sram_wdata = data_gnt ? data_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      is_write   <= 1'b0;
      hold_q     <= '0;
      starve_cnt <= '0;
      rst_q      <= 1'b1;
    end else begin
      rst_q <= 1'b0;

      case (state)
        S_IDLE: if (sram_en) state <= S_WAIT;
        S_WAIT: begin
          if (owner_rready) begin
            state <= sram_en ? S_WAIT : S_IDLE;
          end else begin
            hold_q <= resp_data;
            state  <= S_HOLD;
          end
        end
        S_HOLD: if (owner_rready) state <= sram_en ? S_WAIT : S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (sram_en) begin
        owner    <= data_gnt;
        is_write <= data_gnt && (data_we != 4'h0);
      end

      if (inst_gnt || !inst_req)
        starve_cnt <= '0;
      else if (data_gnt && (starve_cnt != STARVE_LIM))
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checked every cycle,
// plus hand-computed literal expectations per scenario.
module tb_mem_port_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_rready, data_req, data_rready;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_we;
  logic        inst_gnt, inst_rvalid, data_gnt, data_rvalid, sram_en;
  logic [31:0] inst_rdata, data_rdata, sram_addr, sram_wdata;
  logic [3:0]  sram_we;
  logic [31:0] sram_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata), .inst_rready(inst_rready),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .data_rready(data_rready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h1C00_0000) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5555_AAAA;
  endfunction

  // SRAM stand-in: reads return memf(addr) one cycle later, otherwise noise.
  always @(posedge clk)
    sram_rdata <= (sram_en && sram_we == 4'h0) ? memf(sram_addr) : $urandom;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Model: one outstanding response at most, whose value is fixed at grant time.
  logic        m_busy = 1'b0, m_owner = 1'b0, m_after = 1'b0;
  logic [31:0] m_val = '0;
  int          m_cnt = 0;

  initial begin
    logic blk, own_rdy, can, e_ig, e_dg, e_iv, e_dv;
    @(posedge clk);
    forever begin
      @(negedge clk);
      blk     = rst || m_after;
      own_rdy = m_owner ? data_rready : inst_rready;
      can     = !blk && (!m_busy || own_rdy);
      e_ig = 1'b0;
      e_dg = 1'b0;
      if (can) begin
        if (inst_req && m_cnt == SM) e_ig = 1'b1;
        else if (data_req)           e_dg = 1'b1;
        else if (inst_req)           e_ig = 1'b1;
      end
      e_iv = !rst && m_busy && !m_owner;
      e_dv = !rst && m_busy && m_owner;

      chk("m_inst_gnt", inst_gnt, e_ig);
      chk("m_data_gnt", data_gnt, e_dg);
      chk("m_sram_en", sram_en, e_ig | e_dg);
      chk("m_sram_we", sram_we, e_dg ? data_we : 4'h0);
      chk("m_sram_addr", sram_addr, e_dg ? data_addr : (e_ig ? inst_addr : 32'h0));
      chk("m_sram_wdata", sram_wdata, e_dg ? data_wdata : 32'h0);
      chk("m_inst_rvalid", inst_rvalid, e_iv);
      chk("m_inst_rdata", inst_rdata, e_iv ? m_val : 32'h0);
      chk("m_data_rvalid", data_rvalid, e_dv);
      chk("m_data_rdata", data_rdata, e_dv ? m_val : 32'h0);

      if (rst) begin
        m_busy = 1'b0; m_owner = 1'b0; m_after = 1'b1; m_cnt = 0; m_val = '0;
      end else begin
        m_after = 1'b0;
        if (!m_busy || own_rdy) begin
          m_busy = e_ig || e_dg;
          if (m_busy) begin
            m_owner = e_dg;
            m_val   = e_dg ? ((data_we != 4'h0) ? 32'h0 : memf(data_addr)) : memf(inst_addr);
          end
        end
        if (e_ig || !inst_req)          m_cnt = 0;
        else if (e_dg && m_cnt < SM)    m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h0; inst_rready = 1'b1;
    data_req = 1'b1; data_we = 4'h0; data_addr = 32'h40; data_wdata = 32'h0;
    data_rready = 1'b1;
    step();
    #2 chk("rst_no_grant", {29'h0, inst_gnt, data_gnt, sram_en}, 32'h0);
    step();

    // Reset mid-access
    rst = 1'b0; inst_req = 1'b0;
    #2 chk("post_rst_blocked", data_gnt, 1'b0);
    step();
    #2 chk("rma_grant", data_gnt, 1'b1);
    step();
    rst = 1'b1;
    #2 chk("rma_rvalid_rst", data_rvalid, 1'b0);
    chk("rma_gnt_rst", data_gnt, 1'b0);
    step();
    rst = 1'b0;
    #2 chk("rma_rvalid_after", data_rvalid, 1'b0);
    chk("rma_gnt_after", {sram_en, data_gnt}, 2'b00);
    step();
    data_req = 1'b0;
    #2 chk("rma_dropped", data_rvalid, 1'b0);
    step();

    // Single fetch
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    #2 chk("sf_gnt", inst_gnt, 1'b1);
    chk("sf_en_we", {sram_en, sram_we}, 5'b1_0000);
    chk("sf_addr", sram_addr, 32'h1C00_0000);
    step();
    inst_req = 1'b0;
    #2 chk("sf_rvalid", inst_rvalid, 1'b1);
    chk("sf_rdata", inst_rdata, 32'hDEAD_BEEF);
    step();

    // Contention: data store beats fetch
    inst_req = 1'b1; inst_addr = 32'h2000;
    data_req = 1'b1; data_we = 4'hF; data_addr = 32'h100; data_wdata = 32'h1234_5678;
    #2 chk("ct_data_gnt", {inst_gnt, data_gnt}, 2'b01);
    chk("ct_sram_we", sram_we, 4'hF);
    chk("ct_wdata", sram_wdata, 32'h1234_5678);
    step();
    data_req = 1'b0; data_we = 4'h0;
    #2 chk("ct_store_ack", {data_rvalid, data_rdata}, {1'b1, 32'h0});
    chk("ct_inst_next", inst_gnt, 1'b1);
    step();
    inst_req = 1'b0;
    #2 chk("ct_inst_rdata", inst_rdata, memf(32'h2000));
    step();

    // Starvation: 4 data grants then 1 fetch grant, repeating
    inst_req = 1'b1; inst_addr = 32'h800;
    data_req = 1'b1; data_addr = 32'h900;
    for (int i = 0; i < 10; i++) begin
      #2 chk("sv_data_gnt", data_gnt, (i % 5) != 4);
      chk("sv_inst_gnt", inst_gnt, (i % 5) == 4);
      step();
    end
    inst_req = 1'b0; data_req = 1'b0;
    step();
    step();

    // Back-pressure on a data load
    data_req = 1'b1; data_addr = 32'h300; data_rready = 1'b0;
    #2 chk("bp_gnt", data_gnt, 1'b1);
    step();
    for (int j = 0; j < 3; j++) begin
      data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h400;
      #2 chk("bp_hold_rvalid", data_rvalid, 1'b1);
      chk("bp_hold_rdata", data_rdata, memf(32'h300));
      chk("bp_no_gnt", {inst_gnt, data_gnt}, 2'b00);
      step();
    end
    data_rready = 1'b1;
    #2 chk("bp_release_rdata", data_rdata, memf(32'h300));
    chk("bp_release_gnt", inst_gnt, 1'b1);
    step();
    inst_req = 1'b0;
    #2 chk("bp_inst_rdata", {inst_rvalid, data_rvalid}, 2'b10);
    chk("bp_inst_val", inst_rdata, memf(32'h400));
    step();

    // Back-to-back alternating reads
    for (int i = 0; i < 6; i++) begin
      data_req  = (i % 2) == 0;
      inst_req  = (i % 2) == 1;
      data_addr = 32'h500 + 32'(i) * 4;
      inst_addr = 32'h600 + 32'(i) * 4;
      #2 chk("bb_gnt", {inst_gnt, data_gnt}, ((i % 2) == 0) ? 2'b01 : 2'b10);
      if (i > 0) begin
        if ((i % 2) == 0) begin
          chk("bb_inst_rvalid", {inst_rvalid, data_rvalid}, 2'b10);
          chk("bb_inst_rdata", inst_rdata, memf(32'h600 + 32'(i - 1) * 4));
        end else begin
          chk("bb_data_rvalid", {inst_rvalid, data_rvalid}, 2'b01);
          chk("bb_data_rdata", data_rdata, memf(32'h500 + 32'(i - 1) * 4));
        end
      end
      step();
    end
    inst_req = 1'b0; data_req = 1'b0;
    #2 chk("bb_last", inst_rdata, memf(32'h600 + 32'd20));
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the fetch stage (instruction reads) and the execute stage (data loads/stores).
- Each cycle it grants at most one requester and drives the SRAM port from the winner.
- It routes the one-cycle-latency read data back to the owner, and holds it in a register when the owner is not ready.
- Data requests have priority. A starvation counter guarantees fetch progress.

Parameters:
STARVE_MAX, 4, consecutive cycles fetch may lose to data before fetch is forced to win (legal range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
inst_req  in  1  fetch read request
inst_addr  in  32  fetch address
inst_gnt  out  1  fetch request accepted this cycle
inst_rvalid  out  1  fetch response valid
inst_rdata  out  32  fetch read data
inst_rready  in  1  fetch accepts response
data_req  in  1  execute request (load or store)
data_we  in  4  byte write enables; 0 means read
data_addr  in  32  data address
data_wdata  in  32  store data
data_gnt  out  1  data request accepted this cycle
data_rvalid  out  1  data response valid (load data or store ack)
data_rdata  out  32  load data; 0 for store acks
data_rready  in  1  execute accepts response
sram_en  out  1  SRAM access enable
sram_we  out  4  SRAM byte write enables
sram_addr  out  32  SRAM address
sram_wdata  out  32  SRAM write data
sram_rdata  in  32  SRAM read data, valid the cycle after sram_en

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, starve_cnt=0, owner/is_write/hold registers cleared.
  - All outputs are 0 in the reset cycle and the cycle after.
  - Any in-flight response is dropped.
- State machine: IDLE (no response outstanding), WAIT (access issued last cycle; response comes straight from sram_rdata), HOLD (response in hold register).
- Issue permission `can_issue`:
  - 1 in IDLE.
  - In WAIT/HOLD, equals the current owner's rready, allowing back-to-back issue.
  - The combinational rready→gnt path is intended.
- Arbitration, when can_issue:
  - If inst_req && starve_cnt==STARVE_MAX, fetch wins.
  - Else if data_req, data wins.
  - Else if inst_req, fetch wins.
  - Else no grant.
  - Exactly one of inst_gnt/data_gnt may be 1. Both are 0 when !can_issue.
- SRAM drive:
  - sram_en = inst_gnt|data_gnt.
  - sram_addr/sram_wdata come from the winner; inst winner gives wdata=0.
  - sram_we = data_gnt ? data_we : 0.
  - All SRAM outputs are 0 when there is no grant.
- Grant transitions to WAIT; next-cycle owner=winner, is_write=(data_we!=0).
- WAIT:
  - Owner rvalid=1. rdata = is_write ? 0 : sram_rdata.
  - If owner rready: go to WAIT if a new grant occurs, else IDLE.
  - Else: capture rdata into hold register and go to HOLD.
- HOLD:
  - Owner rvalid=1, rdata=hold register, stable until accepted.
  - If rready: go to WAIT on a grant, else IDLE.
- The non-owner's rvalid is always 0. Its rdata is 0.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) when inst_req && data_gnt.
  - Clears when inst_gnt or !inst_req.
  - Holds otherwise, including while !can_issue.
- Latency and throughput:
  - Grant at cycle t gives response at t+1 at the earliest.
  - Sustained throughput is 1 access/cycle when owners are always ready.
- Requesters must hold req/addr/wdata/we stable until gnt. The arbiter does not latch requests.
- Simultaneous events:
  - Response acceptance and new grant in the same cycle are legal.
  - A new grant may go to either requester regardless of the previous owner.

Test Plan:
- Reset mid-access: grant data read at cycle 3, assert rst at cycle 4 → no rvalid at cycle 4 or 5; all outputs 0; state IDLE.
- Single fetch: inst_req, addr 0x1C000000, SRAM returns 0xDEADBEEF → inst_gnt=1 at t, sram_en=1/sram_we=0 at t, inst_rvalid=1 with inst_rdata=0xDEADBEEF at t+1.
- Contention priority: inst_req and data_req both high with data_we=0xF, wdata=0x12345678, addr 0x100 → data_gnt first; sram_we=0xF; data_rvalid=1 with rdata=0 next cycle; inst_gnt the following cycle.
- Starvation, STARVE_MAX=4: inst_req and data_req continuously high, rready=1 → exactly 4 data grants, then 1 inst grant, then pattern repeats; starve_cnt returns to 0 after the inst grant.
- Back-pressure: data load granted, data_rready=0 for 3 cycles while SRAM rdata changes → data_rdata stays at the value from t+1; no grants during HOLD; upon rready=1 a pending inst_req is granted in the same cycle.
- Back-to-back: alternating reads with rready=1 → one grant per cycle; each rvalid is routed to the correct owner with the matching data.
